// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end.
// Contents: channel index constants, the 3-bit button vector type, default
// timing constants (cycles at 25 MHz), the auto-repeat FSM state type and a
// counter-width helper.
package button_pkg;

  localparam int unsigned BTN_RIGHT = 0;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_DROP  = 2;
  localparam int unsigned NUM_BTN   = 3;

  // Bit order everywhere: {drop, left, right}
  typedef logic [2:0] btn_vec_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250_000;    // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 12_500_000; // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = 3_750_000;  // 0.15 s

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_REPEAT
  } rpt_state_e;

  // Width of a counter that must reach n-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: optional inversion, 2-FF synchronizer, debounce counter
// and press (rising-edge) detect. With BUTTON_AUTO_REPEAT_EN defined, a
// hold/repeat FSM is added when REPEAT_EN is set for this instance.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   raw_in     : asynchronous raw button level
//   level      : debounced level (registered)
//   press_evt  : one-cycle candidate event (press, or auto-repeat tick)
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`ifdef BUTTON_AUTO_REPEAT_EN
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b0,
`endif
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic press_evt
);

  localparam int unsigned         CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic             rise;

  always_comb begin
    meta_d       = raw_in ^ ACTIVE_LOW;
    sync_d       = meta_q;
    cnt_d        = '0;
    level_d      = level_q;
    level_prev_d = level_q;
    // Counter only runs while the synchronized level disagrees; reaching the
    // last count with disagreement still present accepts the new level.
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q       <= 1'b0;
      sync_q       <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
    end
  end

  always_comb rise = level_q & ~level_prev_q;
  always_comb level = level_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  if (REPEAT_EN) begin : g_repeat
    localparam int unsigned      RPT_N = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned      RPT_W = cnt_width(RPT_N);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    rpt_state_e       rstate_q, rstate_d;
    logic [RPT_W-1:0] rcnt_q, rcnt_d;
    logic             rpt_fire;

    // The repeat tick is decoded from registered state/count; the top-level
    // output register supplies the cycle of latency shared with presses.
    always_comb begin
      rstate_d = rstate_q;
      rcnt_d   = '0;
      rpt_fire = 1'b0;
      unique case (rstate_q)
        RPT_IDLE: begin
          if (rise) rstate_d = RPT_HOLD;
        end
        RPT_HOLD: begin
          if (rcnt_q == DELAY_LAST) begin
            rpt_fire = 1'b1;
            rstate_d = RPT_REPEAT;
          end else begin
            rcnt_d = rcnt_q + RPT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (rcnt_q == PERIOD_LAST) begin
            rpt_fire = 1'b1;
          end else begin
            rcnt_d = rcnt_q + RPT_W'(1);
          end
        end
        default: rstate_d = RPT_IDLE;
      endcase
      if (!level_q) begin
        rstate_d = RPT_IDLE;
        rcnt_d   = '0;
        rpt_fire = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rstate_q <= RPT_IDLE;
        rcnt_q   <= '0;
      end else begin
        rstate_q <= rstate_d;
        rcnt_q   <= rcnt_d;
      end
    end

    always_comb press_evt = rise | rpt_fire;
  end else begin : g_no_repeat
    always_comb press_evt = rise;
  end
`else
  always_comb press_evt = rise;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Button front end for the Connect Four top level: three raw buttons are
// synchronized and debounced, press edges detected, then arbitrated into
// registered, mutually exclusive single-cycle commands.
// Optional feature macro: BUTTON_AUTO_REPEAT_EN (left/right auto-repeat while
// held; REPEAT_DELAY / REPEAT_PERIOD exist only when it is defined).
// Ports:
//   clk_25MHz                 : sole clock
//   rst                       : synchronous active-high reset
//   btn_right_raw/left/drop   : asynchronous raw button levels
//   move_right/move_left/drop_piece : one-cycle command pulses (one-hot or zero)
//   btn_state                 : debounced levels {drop, left, right}
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`ifdef BUTTON_AUTO_REPEAT_EN
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
`endif
  parameter bit          ACTIVE_LOW_BTN  = 1'b0
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic       btn_right_raw,
  input  logic       btn_left_raw,
  input  logic       btn_drop_raw,
  output logic       move_right,
  output logic       move_left,
  output logic       drop_piece,
  output logic [2:0] btn_state
);

  btn_vec_t raw_vec;
  btn_vec_t level_vec;
  btn_vec_t evt_vec;
  btn_vec_t cmd_q, cmd_d;

  always_comb raw_vec = {btn_drop_raw, btn_left_raw, btn_right_raw};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef BUTTON_AUTO_REPEAT_EN
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (i != BTN_DROP),
`endif
      .ACTIVE_LOW      (ACTIVE_LOW_BTN)
    ) u_ch (
      .clk       (clk_25MHz),
      .rst       (rst),
      .raw_in    (raw_vec[i]),
      .level     (level_vec[i]),
      .press_evt (evt_vec[i])
    );
  end

  // Drop wins outright; simultaneous left+right cancel each other.
  // Losing events are discarded, never deferred.
  always_comb begin
    cmd_d = '0;
    if (evt_vec[BTN_DROP]) begin
      cmd_d[BTN_DROP] = 1'b1;
    end else if (evt_vec[BTN_LEFT] ^ evt_vec[BTN_RIGHT]) begin
      cmd_d[BTN_LEFT]  = evt_vec[BTN_LEFT];
      cmd_d[BTN_RIGHT] = evt_vec[BTN_RIGHT];
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
    end
  end

  always_comb begin
    move_right = cmd_q[BTN_RIGHT];
    move_left  = cmd_q[BTN_LEFT];
    drop_piece = cmd_q[BTN_DROP];
    btn_state  = level_vec;
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  import button_pkg::*;

  localparam int unsigned DEB       = 4;
  localparam int          RPT_DELAY = 20;
  localparam int          RPT_PER   = 8;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic     clk = 1'b0;
  logic     rst;
  btn_vec_t raw, raw_n;
  logic     mr, ml, dp;
  logic     mr_n, ml_n, dp_n;
  btn_vec_t st, st_n;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #20 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
`ifdef BUTTON_AUTO_REPEAT_EN
    .REPEAT_DELAY    (RPT_DELAY),
    .REPEAT_PERIOD   (RPT_PER),
`endif
    .ACTIVE_LOW_BTN  (1'b0)
  ) dut (
    .clk_25MHz     (clk),
    .rst           (rst),
    .btn_right_raw (raw[0]),
    .btn_left_raw  (raw[1]),
    .btn_drop_raw  (raw[2]),
    .move_right    (mr),
    .move_left     (ml),
    .drop_piece    (dp),
    .btn_state     (st)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
`ifdef BUTTON_AUTO_REPEAT_EN
    .REPEAT_DELAY    (RPT_DELAY),
    .REPEAT_PERIOD   (RPT_PER),
`endif
    .ACTIVE_LOW_BTN  (1'b1)
  ) dut_n (
    .clk_25MHz     (clk),
    .rst           (rst),
    .btn_right_raw (raw_n[0]),
    .btn_left_raw  (raw_n[1]),
    .btn_drop_raw  (raw_n[2]),
    .move_right    (mr_n),
    .move_left     (ml_n),
    .drop_piece    (dp_n),
    .btn_state     (st_n)
  );

  typedef struct {
    logic     rst;
    btn_vec_t raw;
    btn_vec_t exp_p;
    btn_vec_t exp_s;
    string    tag;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input btn_vec_t got, input btn_vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Drive inputs, clock once, then compare dut outputs 1 time unit later.
  task automatic step(input logic r, input btn_vec_t b, input btn_vec_t ep,
                      input btn_vec_t es, input string tag);
    rst = r;
    raw = b;
    @(posedge clk);
    #1;
    check({tag, " pulse"}, {dp, ml, mr}, ep);
    check({tag, " state"}, st, es);
  endtask

  task automatic add(input int n, input logic r, input btn_vec_t b,
                     input btn_vec_t ep, input btn_vec_t es, input string tag);
    for (int i = 0; i < n; i++) tbl.push_back('{r, b, ep, es, tag});
  endtask

  // Pulse expected at k for a press first sampled at edge 0 and released
  // (first low sample) at edge `hold`.
  function automatic bit exp_pulse(input int k, input int hold);
    int first_rpt;
    first_rpt = DEB + 2 + RPT_DELAY;
    if (k == DEB + 2) return 1'b1;
    if (RPT_ON && k >= first_rpt && ((k - first_rpt) % RPT_PER) == 0 && k <= hold + DEB + 1)
      return 1'b1;
    return 1'b0;
  endfunction

  task automatic hold_seq(input btn_vec_t b, input int hold, input int total, input string tag);
    for (int k = 0; k < total; k++) begin
      btn_vec_t ep, es, drv;
      ep  = exp_pulse(k, hold) ? b : 3'b000;
      es  = (k >= DEB + 1 && k < hold + DEB + 1) ? b : 3'b000;
      drv = (k < hold) ? b : 3'b000;
      step(1'b0, drv, ep, es, $sformatf("%s[%0d]", tag, k));
    end
  endtask

  initial begin
    rst   = 1'b1;
    raw   = 3'b000;
    raw_n = 3'b111;

    // Reset and idle
    add(2, 1'b1, 3'b000, 3'b000, 3'b000, "reset");
    add(2, 1'b0, 3'b000, 3'b000, 3'b000, "idle");
    // Left glitching every cycle: never accepted
    for (int i = 0; i < 10; i++)
      add(1, 1'b0, (i % 2 == 0) ? 3'b010 : 3'b000, 3'b000, 3'b000, "glitch");
    add(6, 1'b0, 3'b000, 3'b000, 3'b000, "glitch_tail");
    // Right+left together: cancelled
    add(5, 1'b0, 3'b011, 3'b000, 3'b000, "rl_sync");
    add(3, 1'b0, 3'b011, 3'b000, 3'b011, "rl_held");
    add(5, 1'b0, 3'b000, 3'b000, 3'b011, "rl_release");
    add(3, 1'b0, 3'b000, 3'b000, 3'b000, "rl_idle");
    // Drop+left together: drop wins
    add(5, 1'b0, 3'b110, 3'b000, 3'b000, "dl_sync");
    add(1, 1'b0, 3'b110, 3'b000, 3'b110, "dl_level");
    add(1, 1'b0, 3'b110, 3'b100, 3'b110, "dl_pulse");
    add(1, 1'b0, 3'b110, 3'b000, 3'b110, "dl_held");
    add(5, 1'b0, 3'b000, 3'b000, 3'b110, "dl_release");
    add(3, 1'b0, 3'b000, 3'b000, 3'b000, "dl_idle");

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].raw, tbl[i].exp_p, tbl[i].exp_s,
           $sformatf("%s#%0d", tbl[i].tag, i));

    // Long holds: single pulse, plus auto-repeat when the feature is built in
    hold_seq(3'b001, 50, 62, "right_hold");
    hold_seq(3'b010, 60, 72, "left_hold");

    // Reset mid-debounce of a held drop press
    for (int k = 0; k < 3; k++)
      step(1'b0, 3'b100, 3'b000, 3'b000, $sformatf("rstmid_pre[%0d]", k));
    for (int k = 3; k < 6; k++)
      step(1'b1, 3'b100, 3'b000, 3'b000, $sformatf("rstmid_rst[%0d]", k));
    for (int k = 6; k < 33; k++)
      step(1'b0, (k < 21) ? 3'b100 : 3'b000,
           (k == 12) ? 3'b100 : 3'b000,
           (k >= 11 && k < 26) ? 3'b100 : 3'b000,
           $sformatf("rstmid_post[%0d]", k));

    // Active-low instance: drop raw 1->0 presses, 0->1 releases silently
    check("n_idle pulse", {dp_n, ml_n, mr_n}, 3'b000);
    check("n_idle state", st_n, 3'b000);
    rst = 1'b0;
    raw = 3'b000;
    for (int k = 0; k < 24; k++) begin
      raw_n = (k < 12) ? 3'b011 : 3'b111;
      @(posedge clk);
      #1;
      check($sformatf("n_drop pulse[%0d]", k), {dp_n, ml_n, mr_n},
            (k == 6) ? 3'b100 : 3'b000);
      check($sformatf("n_drop state[%0d]", k), st_n,
            (k >= 5 && k < 17) ? 3'b100 : 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
